// File: rtl/call_stack_pkg.sv
// Shared defaults, FSM state encoding and error codes for the hardware call stack.
package call_stack_pkg;

   localparam int unsigned DEPTH_DEF = 8;
   localparam int unsigned AW_DEF    = 10;

   typedef enum logic {
      ST_RUN = 1'b0,
      ST_ERR = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      ERR_NONE = 2'b00,
      ERR_OVF  = 2'b01,
      ERR_UDF  = 2'b10
   } err_code_t;

endpackage

// File: rtl/stack_mem.sv
// Return-address storage: one synchronous write port, one combinational read port.
module stack_mem #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned AW    = 10
) (
   input  logic                     clk,
   input  logic                     i_we,
   input  logic [$clog2(DEPTH)-1:0] i_waddr,
   input  logic [AW-1:0]            i_wdata,
   input  logic [$clog2(DEPTH)-1:0] i_raddr,
   output logic [AW-1:0]            o_rdata
);

   logic [AW-1:0] r_mem [DEPTH];

   // NOTE: storage has no reset; validity is tracked by the depth counter, so
   // resetting every entry would only add a large reset fan-out for nothing.
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/call_stack_ctrl.sv
// Call/return stack controller: depth counter, RUN/ERR FSM with sticky overflow
// and underflow reporting, and a zero-latency top-of-stack read for the PC mux.
module call_stack_ctrl
   import call_stack_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEF,
   parameter int unsigned AW    = AW_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     call,
   input  logic                     ret,
   input  logic [AW-1:0]            ret_in,
   input  logic                     clr_err,
   output logic [AW-1:0]            top,
   output logic [$clog2(DEPTH):0]   depth,
   output logic                     empty,
   output logic                     full,
   output logic                     err,
   output logic [1:0]               err_code
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned DW = PW + 1;

   state_t       r_state;
   err_code_t    r_err_code;
   logic [DW-1:0] r_depth;

   state_t        w_state_nxt;
   err_code_t     w_err_code_nxt;
   logic [DW-1:0] w_depth_nxt;
   logic          w_we;
   logic [PW-1:0] w_waddr;
   logic [PW-1:0] w_top_idx;
   logic [AW-1:0] w_rdata;
   logic          w_empty;
   logic          w_full;

   assign w_empty = (r_depth == '0);
   assign w_full  = (r_depth == DW'(DEPTH));
   // Low bits of depth-1 wrap to DEPTH-1 when full, which is exactly the top slot.
   assign w_top_idx = r_depth[PW-1:0] - PW'(1);

   // NOTE: every signal driven here gets a default first so no path can infer a latch.
   always_comb begin
      w_state_nxt    = r_state;
      w_err_code_nxt = r_err_code;
      w_depth_nxt    = r_depth;
      w_we           = 1'b0;
      w_waddr        = r_depth[PW-1:0];
      unique case (r_state)
         ST_RUN: begin
            if (ret && w_empty) begin
               w_state_nxt    = ST_ERR;
               w_err_code_nxt = ERR_UDF;
            end else if (call && ret) begin
               w_we    = 1'b1;
               w_waddr = w_top_idx;
            end else if (ret) begin
               w_depth_nxt = r_depth - DW'(1);
            end else if (call && w_full) begin
               w_state_nxt    = ST_ERR;
               w_err_code_nxt = ERR_OVF;
            end else if (call) begin
               w_we        = 1'b1;
               w_depth_nxt = r_depth + DW'(1);
            end
         end
         ST_ERR: begin
            if (clr_err) begin
               w_state_nxt    = ST_RUN;
               w_err_code_nxt = ERR_NONE;
            end
         end
         default: begin
            w_state_nxt    = ST_RUN;
            w_err_code_nxt = ERR_NONE;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= ST_RUN;
         r_err_code <= ERR_NONE;
         r_depth    <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_err_code <= w_err_code_nxt;
         r_depth    <= w_depth_nxt;
      end
   end

   stack_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_stack_mem (
      .clk     (clk),
      .i_we    (w_we && reset),
      .i_waddr (w_waddr),
      .i_wdata (ret_in),
      .i_raddr (w_top_idx),
      .o_rdata (w_rdata)
   );

   assign top      = w_empty ? '0 : w_rdata;
   assign depth    = r_depth;
   assign empty    = w_empty;
   assign full     = w_full;
   assign err      = (r_state == ST_ERR);
   assign err_code = r_err_code;

endmodule

// File: doc/call_stack_ctrl.md
CALL_STACK_CTRL -- requirements
Module: call_stack_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8, return-address entries held (power of two, >=2).
REQ-002 SHALL have parameter AW, default 10, return-address width matching the PC width.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port call  input  1  push request: store ret_in this cycle.
REQ-006 SHALL have port ret  input  1  pop request: discard the top entry this cycle.
REQ-007 SHALL have port ret_in  input  AW  return address to push (PC+1 from the PC adder).
REQ-008 SHALL have port clr_err  input  1  leaves the ERR state.
REQ-009 SHALL have port top  output  AW  current top-of-stack address, fed to the PC mux.
REQ-010 SHALL have port depth  output  $clog2(DEPTH)+1  number of valid entries, 0..DEPTH.
REQ-011 SHALL have port empty  output  1  depth==0.
REQ-012 SHALL have port full  output  1  depth==DEPTH.
REQ-013 SHALL have port err  output  1  high while in ERR; the CPU stalls on it.
REQ-014 SHALL have port err_code  output  2  00 none, 01 overflow, 10 underflow; held while err.

Function
REQ-015 SHALL implement FSM states RUN and ERR.
REQ-016 In RUN, call only, not full: SHALL write ret_in at mem[depth] and increment depth.
REQ-017 In RUN, ret only, not empty: SHALL decrement depth; the entry is not cleared.
REQ-018 In RUN, call and ret together, not empty: SHALL overwrite mem[depth-1] with ret_in, depth unchanged (tail call).
REQ-019 In RUN, call with full and no ret: SHALL go to ERR with err_code 01, no write, depth unchanged.
REQ-020 In RUN, ret with empty (with or without call): SHALL go to ERR with err_code 10, no push, depth unchanged.
REQ-021 top SHALL be combinational mem[depth-1] when not empty and 0 when empty, so a ret uses the same-cycle top with zero latency.
REQ-022 err and err_code SHALL be registered: they assert the cycle after the offending request.
REQ-023 In ERR: call and ret SHALL be ignored, and stack contents and depth frozen.
REQ-024 In ERR, clr_err SHALL return to RUN next cycle with err_code 00, keeping depth and contents.
REQ-025 clr_err in RUN SHALL have no effect.
REQ-026 Depth arithmetic SHALL never wrap; the pointer stays in 0..DEPTH.
REQ-027 empty, full and depth SHALL be derived from the registered depth only.

Reset
REQ-028 reset low at a rising edge SHALL force RUN, depth 0, err 0, err_code 00, and override any same-cycle call/ret/clr_err.
REQ-029 Storage contents need not be reset; top SHALL read 0 after reset because empty is high.
REQ-030 Reset mid-sequence, including in ERR, SHALL discard all entries with no partial push.

Structure
REQ-031 call_stack_pkg SHALL hold DEPTH and AW defaults, the state encoding (RUN, ERR) and err_code constants (NONE, OVF, UDF).
REQ-032 Storage SHALL be one sub-module, stack_mem: DEPTH x AW, single synchronous write port and one combinational read port, no reset.
REQ-033 FSM, depth counter and error logic SHALL live in call_stack_ctrl; no latches and no combinational loops.

Verification
REQ-034 Reset, then push 0x011, 0x022, 0x033 on successive cycles -> depth 3, top 0x033; one ret -> top 0x022, depth 2.
REQ-035 Push 8 values 0x100..0x107 -> full 1, top 0x107; a 9th call -> next cycle err 1, err_code 01, depth 8, top 0x107.
REQ-036 Empty stack, ret -> err 1, err_code 10, depth 0; call during ERR ignored; clr_err -> RUN, err 0, depth 0.
REQ-037 Depth 2 (0x050, 0x060), call+ret with ret_in 0x070 -> depth 2, top 0x070; ret -> top 0x050.
REQ-038 Depth 5, reset low for one cycle with call high -> depth 0, empty 1, top 0, err 0.
REQ-039 Random call/ret for 10k cycles against a queue reference model -> top, depth, full, empty, err and err_code match every cycle.
